// File: rtl/float_pkg.sv
// Shared float format constants, packed-word field offsets and the normalizer state encoding.
// Used by float_normalizer and the accumulator's adder.
package float_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int BIAS     = 2 ** (EXP_W - 1) - 1;
  localparam int EXP_ONES = 2 ** EXP_W - 1;

  // Packed word layout: {sign, exp, frac}
  localparam int WORD_W   = 1 + EXP_W + MAN_W;
  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = MAN_W;
  localparam int SIGN_BIT = EXP_W + MAN_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } norm_state_e;

endpackage

// File: rtl/float_round_rne.sv
// Round-to-nearest-even increment of a normalized mantissa given its guard and sticky bits.
// carry is set when the increment overflows past the hidden bit.
module float_round_rne
  import float_pkg::*;
(
  input  logic [MAN_W:0] mant,
  input  logic           guard,
  input  logic           sticky,
  output logic [MAN_W:0] mant_rnd,
  output logic           carry
);

  logic inc;

  assign inc               = guard & (sticky | mant[0]);
  assign {carry, mant_rnd} = {1'b0, mant} + (MAN_W + 2)'(inc);

endmodule

// File: rtl/float_normalizer.sv
// Multi-cycle normalize-round-pack unit: shifts the raw magnitude one bit per clock until the
// hidden bit sits at MAN_W, rounds, and emits {sign, exp, frac}. FLOAT_NORM_ROUND_EN selects RNE.
module float_normalizer
  import float_pkg::*;
#(
  parameter int RAW_W = 48
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [RAW_W-1:0]  in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(EXP_ONES);

  norm_state_e       state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [RAW_W-1:0]  mant_q, mant_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

  logic accept, too_big, shift_right;
  logic guard_q, sticky_q;

  assign accept      = in_valid && (state_q == ST_IDLE);
  assign too_big     = |mant_q[RAW_W-1:MAN_W+1];
  assign shift_right = (state_q == ST_NORM) && (mant_q != '0) && too_big
                       && (exp_q < EXP_MAX - EXP_W'(1));

`ifdef FLOAT_NORM_ROUND_EN
  // Sticky collects every bit that has fallen past the guard position.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else if (accept) begin
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else if (shift_right) begin
      guard_q  <= mant_q[0];
      sticky_q <= sticky_q | guard_q;
    end
  end
`else
  assign guard_q  = 1'b0;
  assign sticky_q = 1'b0;
`endif

  logic [MAN_W:0]   mant_rnd;
  logic             carry;
  logic [EXP_W:0]   exp_rnd;

  float_round_rne u_round (
    .mant     (mant_q[MAN_W:0]),
    .guard    (guard_q),
    .sticky   (sticky_q),
    .mant_rnd (mant_rnd),
    .carry    (carry)
  );

  assign exp_rnd = {1'b0, exp_q} + (EXP_W + 1)'(carry);

  // NOTE: every variable assigned here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    word_d  = word_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_NORM;
          sign_d  = in_sign;
          exp_d   = in_exp;
          mant_d  = in_mant;
        end
      end
      ST_NORM: begin
        if (mant_q == '0) begin
          state_d = ST_DONE;
          word_d  = {sign_q, {(EXP_W + MAN_W){1'b0}}};
          {zero_d, ovf_d, unf_d} = 3'b100;
        end else if (too_big) begin
          if (shift_right) begin
            mant_d = mant_q >> 1;
            exp_d  = exp_q + EXP_W'(1);
          end else begin
            state_d = ST_DONE;
            word_d  = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            {zero_d, ovf_d, unf_d} = 3'b010;
          end
        end else if (!mant_q[MAN_W] && exp_q <= EXP_W'(1)) begin
          state_d = ST_DONE;
          word_d  = {sign_q, {(EXP_W + MAN_W){1'b0}}};
          {zero_d, ovf_d, unf_d} = 3'b001;
        end else if (!mant_q[MAN_W]) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - EXP_W'(1);
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = ST_DONE;
        if (exp_rnd >= (EXP_W + 1)'(EXP_ONES)) begin
          word_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
          {zero_d, ovf_d, unf_d} = 3'b010;
        end else begin
          // A rounding carry leaves 1.000..0 after the renormalizing shift.
          word_d = {sign_q, exp_rnd[EXP_W-1:0], carry ? {MAN_W{1'b0}} : mant_rnd[MAN_W-1:0]};
          {zero_d, ovf_d, unf_d} = 3'b000;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      word_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      word_q  <= word_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_word  = word_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

endmodule

// File: tb/tb_float_normalizer.sv
// Directed, table-driven bench for float_normalizer: result word, flags and latency per vector,
// plus output stall and mid-operation reset sequences.
module tb_float_normalizer;

`ifdef FLOAT_NORM_ROUND_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic        out_zero, out_ovf, out_unf;

  float_normalizer #(.RAW_W(48)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [47:0] mant;
    logic [31:0] word_rne;
    logic [31:0] word_trn;
    logic [2:0]  flg_rne;   // {zero, ovf, unf}
    logic [2:0]  flg_trn;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(logic s, logic [7:0] e, logic [47:0] m, logic [31:0] wr,
                              logic [31:0] wt, logic [2:0] fr, logic [2:0] ft, int l);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.word_rne = wr; v.word_trn = wt;
    v.flg_rne = fr; v.flg_trn = ft; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    else n_pass++;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   n;
    int   lat;
    v = vecs[i];
    @(negedge Clk);
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    @(posedge Clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 80) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check($sformatf("v%0d latency", i), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d word", i), 64'(out_word), 64'(RNE ? v.word_rne : v.word_trn));
    check($sformatf("v%0d flags", i), 64'({out_zero, out_ovf, out_unf}),
          64'(RNE ? v.flg_rne : v.flg_trn));
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int bad;
    vecs.push_back(mk(0, 127, 48'(1) << 23, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 2));
    vecs.push_back(mk(0, 127, 48'(3) << 23, 32'h40400000, 32'h40400000, 3'b000, 3'b000, 3));
    vecs.push_back(mk(0, 130, 48'(1) << 20, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 5));
    vecs.push_back(mk(0, 127, (48'(1) << 24) + 48'd3, 32'h40000002, 32'h40000001, 3'b000, 3'b000, 3));
    vecs.push_back(mk(0, 254, 48'(1) << 24, 32'h7F800000, 32'h7F800000, 3'b010, 3'b010, 1));
    vecs.push_back(mk(0, 1, 48'(1) << 22, 32'h00000000, 32'h00000000, 3'b001, 3'b001, 1));
    vecs.push_back(mk(1, 100, 48'd0, 32'h80000000, 32'h80000000, 3'b100, 3'b100, 1));
    vecs.push_back(mk(0, 127, (48'(1) << 24) + 48'd1, 32'h40000000, 32'h40000000, 3'b000, 3'b000, 3));
    vecs.push_back(mk(0, 127, (48'(1) << 25) + 48'd3, 32'h40800001, 32'h40800000, 3'b000, 3'b000, 4));
    vecs.push_back(mk(0, 127, (48'(1) << 25) - 48'd1, 32'h40800000, 32'h407FFFFF, 3'b000, 3'b000, 3));
    vecs.push_back(mk(0, 253, (48'(1) << 25) - 48'd1, 32'h7F800000, 32'h7F7FFFFF, 3'b010, 3'b000, 3));
    vecs.push_back(mk(1, 140, 48'(1) << 47, 32'hD2000000, 32'hD2000000, 3'b000, 3'b000, 26));
    vecs.push_back(mk(0, 3, 48'(1) << 20, 32'h00000000, 32'h00000000, 3'b001, 3'b001, 3));
    vecs.push_back(mk(0, 200, 48'd1, 32'h58800000, 32'h58800000, 3'b000, 3'b000, 25));

    #3;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_word", 64'(out_word), 64'd0);
    check("reset flags", 64'({out_zero, out_ovf, out_unf}), 64'd0);
    #17 Rst = 1'b1;

    foreach (vecs[i]) run_vec(i);

    // Stall: hold out_ready low for 10 cycles with a result pending.
    @(negedge Clk);
    in_exp = 127; in_mant = 48'(1) << 23; in_sign = 0; in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    bad = 0;
    while (!out_valid && bad < 20) begin
      @(posedge Clk);
      #1 bad++;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      #1;
      check("stall out_word", 64'(out_word), 64'h3F800000);
      check("stall in_ready", 64'(in_ready), 64'd0);
      check("stall out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;

    // Reset during NORM aborts the operation.
    @(negedge Clk);
    in_exp = 130; in_mant = 48'(1) << 20; in_sign = 0; in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(posedge Clk);
    #1 Rst = 1'b0;
    #2;
    check("abort in_ready", 64'(in_ready), 64'd1);
    @(negedge Clk);
    Rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk);
      #1 if (out_valid) bad++;
    end
    check("abort no out_valid", 64'(bad), 64'd0);
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
